// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter.
//   - FSM state encodings (3-bit, so illegal codes exist and are recovered)
//   - parity mode codes as seen on i_parity_mode
//   - frame_bits(): total bit periods in one frame for a given format
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_PARITY = 3'd3;
    localparam state_t S_STOP   = 3'd4;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Start + data + optional parity + one or two stop bits.
    function automatic int frame_bits(input int word_len, input logic [1:0] mode,
                                      input logic two_stop);
        return 1 + word_len + (((mode == PAR_EVEN) || (mode == PAR_ODD)) ? 1 : 0)
                 + (two_stop ? 2 : 1);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO feeding the UART shift register.
//   i_push/i_data   write side; ignored while full (even with a same-edge pop)
//   i_pop/o_data    read side; o_data is the head word, valid while !o_empty
//   o_full/o_empty  status flags
//   o_count         words currently stored
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int p_WIDTH = 8,
    parameter int p_DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [p_WIDTH-1:0]           i_data,
    input  logic                         i_pop,
    output logic [p_WIDTH-1:0]           o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(p_DEPTH+1)-1:0] o_count
);

    localparam int PW = $clog2(p_DEPTH);
    localparam int CW = $clog2(p_DEPTH+1);

    logic [p_WIDTH-1:0] mem [p_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign o_full  = (o_count == CW'(p_DEPTH));
    assign o_empty = (o_count == '0);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_data  = mem[rd_ptr];

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   o_count <= o_count + CW'(1);
                2'b01:   o_count <= o_count - CW'(1);
                default: o_count <= o_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an input FIFO and selectable frame format.
//   i_data/i_valid/o_ready  producer handshake into the FIFO
//   i_parity_mode           00/11 none, 01 even, 10 odd (latched per frame)
//   i_two_stop              two stop bits when 1 (latched per frame)
//   o_tx                    serial line, idle high, LSB first
//   o_busy                  a frame is in progress
//   o_done                  one-cycle pulse during the frame's last stop cycle
//   o_fifo_count            words waiting in the FIFO
// o_tx is registered from the current state, so the line trails the FSM by
// one cycle; o_done is registered the same way and lines up with the line.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int p_CLK_DIV    = 104,
    parameter int p_WORD_LEN   = 8,
    parameter int p_FIFO_DEPTH = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [p_WORD_LEN-1:0]             i_data,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [1:0]                        i_parity_mode,
    input  logic                              i_two_stop,
    output logic                              o_tx,
    output logic                              o_busy,
    output logic                              o_done,
    output logic [$clog2(p_FIFO_DEPTH+1)-1:0] o_fifo_count
);

    localparam int BW = $clog2(p_CLK_DIV);
    localparam int NW = $clog2(p_WORD_LEN+1);

    state_t                state;
    logic [BW-1:0]         baud;
    logic [NW-1:0]         bit_cnt;
    logic [p_WORD_LEN-1:0] shreg;
    logic                  par_bit;
    logic [1:0]            mode_l;
    logic                  two_l;
    logic                  second_stop;

    logic [p_WORD_LEN-1:0] head;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  baud_last;
    logic                  stop_last;
    logic                  has_par;

    assign o_ready   = !full && !i_rst;
    assign push      = i_valid && o_ready;
    assign baud_last = (baud == BW'(p_CLK_DIV-1));
    assign stop_last = !two_l || second_stop;
    assign has_par   = (mode_l == PAR_EVEN) || (mode_l == PAR_ODD);

    // Pop from IDLE, or on the final stop cycle so the next frame starts
    // without an idle gap.
    always_comb begin
        pop = 1'b0;
        case (state)
            S_IDLE:  pop = !empty;
            S_STOP:  pop = baud_last && stop_last && !empty;
            default: pop = 1'b0;
        endcase
    end

    uart_sync_fifo #(
        .p_WIDTH (p_WORD_LEN),
        .p_DEPTH (p_FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  (i_data),
        .i_pop   (pop),
        .o_data  (head),
        .o_full  (full),
        .o_empty (empty),
        .o_count (o_fifo_count)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            baud        <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            mode_l      <= PAR_NONE;
            two_l       <= 1'b0;
            second_stop <= 1'b0;
            o_tx        <= 1'b1;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;

            // Frame setup; parity comes from the whole word before shifting.
            if (pop) begin
                shreg   <= head;
                par_bit <= (^head) ^ (i_parity_mode == PAR_ODD);
                mode_l  <= i_parity_mode;
                two_l   <= i_two_stop;
                baud    <= '0;
                state   <= S_START;
                o_busy  <= 1'b1;
            end

            case (state)
                S_IDLE: o_tx <= 1'b1;

                S_START: begin
                    o_tx <= 1'b0;
                    if (baud_last) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end

                S_DATA: begin
                    o_tx <= shreg[0];
                    if (baud_last) begin
                        baud    <= '0;
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + NW'(1);
                        if (bit_cnt == NW'(p_WORD_LEN-1)) begin
                            second_stop <= 1'b0;
                            state       <= has_par ? S_PARITY : S_STOP;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end

                S_PARITY: begin
                    o_tx <= par_bit;
                    if (baud_last) begin
                        baud        <= '0;
                        second_stop <= 1'b0;
                        state       <= S_STOP;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end

                S_STOP: begin
                    o_tx <= 1'b1;
                    if (baud_last) begin
                        if (!stop_last) begin
                            baud        <= '0;
                            second_stop <= 1'b1;
                        end else begin
                            o_done <= 1'b1;
                            if (empty) begin
                                baud   <= '0;
                                state  <= S_IDLE;
                                o_busy <= 1'b0;
                            end
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    baud   <= '0;
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: an 8-bit and a 5-bit instance, both p_CLK_DIV=4.
// Expected frames are built from each pushed word and queued; a line monitor
// pops them on every start bit and checks the line, o_done and o_busy per cycle.
module tb_uart_tx_fifo;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] data8;
    logic       valid8, ready8, two8, tx8, busy8, done8;
    logic [1:0] mode8;
    logic [2:0] cnt8;

    logic [4:0] data5;
    logic       valid5, ready5, two5, tx5, busy5, done5;
    logic [1:0] mode5;
    logic [2:0] cnt5;

    uart_tx_fifo #(.p_CLK_DIV(DIV), .p_WORD_LEN(8), .p_FIFO_DEPTH(4)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_data(data8), .i_valid(valid8), .o_ready(ready8),
        .i_parity_mode(mode8), .i_two_stop(two8), .o_tx(tx8), .o_busy(busy8),
        .o_done(done8), .o_fifo_count(cnt8)
    );

    uart_tx_fifo #(.p_CLK_DIV(DIV), .p_WORD_LEN(5), .p_FIFO_DEPTH(4)) dut5 (
        .i_clk(clk), .i_rst(rst), .i_data(data5), .i_valid(valid5), .o_ready(ready5),
        .i_parity_mode(mode5), .i_two_stop(two5), .o_tx(tx5), .o_busy(busy5),
        .o_done(done5), .o_fifo_count(cnt5)
    );

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    frame_t sb[$];
    frame_t cur;
    int     n_checks = 0;
    int     n_fail   = 0;
    int     done_cnt = 0;
    int     idx      = 0;
    int     base     = 0;
    bit     active   = 1'b0;
    logic   sel      = 1'b0;

    logic tx_m, done_m, busy_m, ready_m;
    assign tx_m    = sel ? tx5    : tx8;
    assign done_m  = sel ? done5  : done8;
    assign busy_m  = sel ? busy5  : busy8;
    assign ready_m = sel ? ready5 : ready8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop 1s.
    function automatic frame_t mk(input logic [8:0] w, input int wl,
                                  input logic [1:0] m, input logic two);
        frame_t f;
        int     n;
        logic   p;
        f.bits    = '1;
        f.bits[0] = 1'b0;
        n = 1;
        p = 1'b0;
        for (int i = 0; i < wl; i++) begin
            f.bits[n] = w[i];
            p = p ^ w[i];
            n++;
        end
        if (m == 2'b01) begin f.bits[n] = p;  n++; end
        else if (m == 2'b10) begin f.bits[n] = ~p; n++; end
        n += two ? 2 : 1;
        f.len = n;
        return f;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [8:0] w);
        bit ok = 1'b0;
        if (sel) begin data5 = w[4:0]; valid5 = 1'b1; end
        else     begin data8 = w[7:0]; valid8 = 1'b1; end
        for (int t = 0; t < 500; t++) begin
            if (ready_m === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("push_accept", ok, 1);
        if (ok) sb.push_back(sel ? mk(w, 5, mode5, two5) : mk(w, 8, mode8, two8));
        @(negedge clk);
        valid5 = 1'b0;
        valid8 = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !active && busy_m === 1'b0) begin ok = 1'b1; break; end
        end
        chk("idle_reached", ok, 1);
    endtask

    // Line monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else begin
                if (!active && tx_m === 1'b0) begin
                    chk("frame_expected", (sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        cur    = sb.pop_front();
                        active = 1'b1;
                        idx    = 0;
                    end
                end
                if (active) begin
                    chk("tx_bit", tx_m, cur.bits[idx / DIV]);
                    chk("done_pos", done_m, (idx == cur.len * DIV - 1));
                    if (idx < cur.len * DIV - 1) chk("busy_in_frame", busy_m, 1);
                    if (done_m === 1'b1) done_cnt++;
                    idx++;
                    if (idx == cur.len * DIV) active = 1'b0;
                end else begin
                    chk("idle_done", done_m, 0);
                end
            end
        end
    end

    initial begin
        data8 = '0; valid8 = 1'b0; mode8 = 2'b00; two8 = 1'b0;
        data5 = '0; valid5 = 1'b0; mode5 = 2'b00; two5 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_tx", tx8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_cnt", cnt8, 0);
        chk("rst_ready", ready8, 0);
        chk("rst_tx5", tx5, 1);
        chk("rst_ready5", ready5, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", ready8, 1);
        chk("rel_cnt", cnt8, 0);

        // Plain 8N1 frame and push-to-line latency
        base = done_cnt;
        push(9'h0A5);
        chk("lat_e0_tx", tx8, 1);
        chk("lat_e0_cnt", cnt8, 1);
        @(negedge clk);
        chk("lat_e1_tx", tx8, 1);
        chk("lat_e1_busy", busy8, 1);
        chk("lat_e1_cnt", cnt8, 0);
        @(negedge clk);
        chk("lat_e2_tx", tx8, 0);
        wait_idle();
        chk("t1_dones", done_cnt - base, 1);

        // Even, odd parity and two stop bits
        base = done_cnt;
        mode8 = 2'b01; push(9'h0A5); wait_idle();
        mode8 = 2'b10; push(9'h0A5); wait_idle();
        mode8 = 2'b00; two8 = 1'b1; push(9'h0A5); wait_idle();
        two8 = 1'b0;
        chk("t2_dones", done_cnt - base, 3);

        // Back-to-back frames: frame k+1 starts right after frame k's done
        base = done_cnt;
        push(9'h001);
        push(9'h002);
        push(9'h003);
        for (int k = 3; k <= 82; k++) begin
            @(negedge clk);
            if (k == 41 || k == 81) chk("b2b_busy", busy8, 1);
            if (k == 42 || k == 82) chk("b2b_start", tx8, 0);
        end
        wait_idle();
        chk("t3_dones", done_cnt - base, 3);

        // Fill to full while busy, then one more word waits for a slot
        base = done_cnt;
        mode8 = 2'b01;
        push(9'h011); push(9'h022); push(9'h033); push(9'h044); push(9'h055);
        chk("full_cnt", cnt8, 4);
        chk("full_ready", ready8, 0);
        push(9'h066);
        wait_idle();
        chk("t4_dones", done_cnt - base, 6);
        mode8 = 2'b00;

        // Reset in the middle of a data bit with two words queued
        push(9'h03C); push(9'h011); push(9'h022);
        chk("pre_rst_cnt", cnt8, 2);
        repeat (5) @(negedge clk);
        chk("pre_rst_tx", tx8, 0);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_tx", tx8, 1);
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_ready", ready8, 0);
        chk("mid_rst_cnt", cnt8, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cnt", cnt8, 0);
        chk("post_rst_ready", ready8, 1);
        base = done_cnt;
        repeat (100) @(negedge clk);
        chk("post_rst_nodone", done_cnt - base, 0);
        chk("post_rst_tx", tx8, 1);

        // 5-bit words; a mid-frame parity change must not affect the frame
        sel = 1'b1;
        base = done_cnt;
        mode5 = 2'b10;
        push(9'h01F);
        repeat (12) @(negedge clk);
        mode5 = 2'b00;
        wait_idle();
        mode5 = 2'b01;
        push(9'h00A);
        wait_idle();
        chk("t6_dones", done_cnt - base, 2);
        chk("t6_cnt", cnt5, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
